// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol type, control tokens and helper functions.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;

    // Control-period tokens, indexed by {c1,c0}
    localparam tmds_sym_t TOK_CTRL00 = 10'h354;
    localparam tmds_sym_t TOK_CTRL01 = 10'h0AB;
    localparam tmds_sym_t TOK_CTRL10 = 10'h154;
    localparam tmds_sym_t TOK_CTRL11 = 10'h2AB;

    // Number of ones in an 8-bit word
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, v[i]};
        end
        return sum;
    endfunction

    // Map the two control bits onto their blanking token
    function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
        tmds_sym_t tok;
        case (c)
            2'b00:   tok = TOK_CTRL00;
            2'b01:   tok = TOK_CTRL01;
            2'b10:   tok = TOK_CTRL10;
            default: tok = TOK_CTRL11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// First TMDS stage: transition-minimising XOR/XNOR chain, registered
// together with the matching de/ctrl so both stay aligned with q_m.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       de_i,
    input  logic [1:0] ctrl_i,
    output logic [8:0] qm_o,
    output logic       de_o,
    output logic [1:0] ctrl_o
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] ctrl_q;

    // Choose XNOR when the byte is ones-heavy, then build the chained q_m word
    always_comb begin
        n1d      = popcount8(data_i);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
        qm_d     = '0;
        qm_d[0]  = data_i[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
        end
        qm_d[8]  = ~use_xnor;
    end

    // Pipeline register; reset flushes to a blanking cycle with ctrl 00
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de_i;
            ctrl_q <= ctrl_i;
        end
    end

    assign qm_o   = qm_q;
    assign de_o   = de_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-lane TMDS encoder: optional input register, q_m stage, then the
// DC-balancing stage with its running-disparity register. Outputs are flops.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter bit RegisterInput = 1'b0,
    parameter int DispWidth     = 5
)
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           data_i,
    input  logic                 de_i,
    input  logic [1:0]           ctrl_i,
    output logic [9:0]           tmds_o,
    output logic [DispWidth-1:0] disp_o
);

    // Two guard bits let the unclamped sum be checked against the counter range
    localparam int WW = DispWidth + 2;

    logic [7:0] s0_data;
    logic       s0_de;
    logic [1:0] s0_ctrl;

    generate
        if (RegisterInput) begin : g_in_reg
            logic [7:0] data_q;
            logic       de_q;
            logic [1:0] ctrl_q;

            // Optional retiming register in front of the encoder
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_q <= '0;
                    de_q   <= 1'b0;
                    ctrl_q <= 2'b00;
                end else begin
                    data_q <= data_i;
                    de_q   <= de_i;
                    ctrl_q <= ctrl_i;
                end
            end

            assign s0_data = data_q;
            assign s0_de   = de_q;
            assign s0_ctrl = ctrl_q;
        end else begin : g_in_pass
            assign s0_data = data_i;
            assign s0_de   = de_i;
            assign s0_ctrl = ctrl_i;
        end
    endgenerate

    logic [8:0] qm_s1;
    logic       de_s1;
    logic [1:0] ctrl_s1;

    tmds_qm_stage u_qm (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (s0_data),
        .de_i   (s0_de),
        .ctrl_i (s0_ctrl),
        .qm_o   (qm_s1),
        .de_o   (de_s1),
        .ctrl_o (ctrl_s1)
    );

    tmds_sym_t                   tmds_q;
    tmds_sym_t                   tmds_d;
    logic signed [DispWidth-1:0] cnt_q;
    logic signed [DispWidth-1:0] cnt_d;

    logic [3:0]           n1;
    logic [3:0]           n0;
    logic signed [WW-1:0] n1_w;
    logic signed [WW-1:0] n0_w;
    logic signed [WW-1:0] cnt_w;
    logic signed [WW-1:0] cnt_sum;
    logic                 cnt_zero;
    logic                 cnt_pos;
    logic                 cnt_neg;
    logic                 qm8;

    // Balance decision: pick inversion of q_m[7:0] to drive disparity to zero
    always_comb begin
        n1       = popcount8(qm_s1[7:0]);
        n0       = 4'd8 - n1;
        n1_w     = $signed({{(WW-4){1'b0}}, n1});
        n0_w     = $signed({{(WW-4){1'b0}}, n0});
        cnt_w    = {{2{cnt_q[DispWidth-1]}}, cnt_q};
        cnt_zero = (cnt_q == '0);
        cnt_neg  = cnt_q[DispWidth-1];
        cnt_pos  = !cnt_zero && !cnt_neg;
        qm8      = qm_s1[8];
        tmds_d   = ctrl_token(ctrl_s1);
        cnt_sum  = '0;

        if (!de_s1) begin
            tmds_d  = ctrl_token(ctrl_s1);
            cnt_sum = '0;
        end else if (cnt_zero || (n1 == n0)) begin
            tmds_d  = {~qm8, qm8, qm8 ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_sum = qm8 ? (cnt_w + n1_w - n0_w) : (cnt_w + n0_w - n1_w);
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
            tmds_d  = {1'b1, qm8, ~qm_s1[7:0]};
            cnt_sum = cnt_w + (qm8 ? WW'(2) : WW'(0)) + n0_w - n1_w;
        end else begin
            tmds_d  = {1'b0, qm8, qm_s1[7:0]};
            cnt_sum = cnt_w + n1_w - n0_w - (qm8 ? WW'(0) : WW'(2));
        end

        cnt_d = cnt_sum[DispWidth-1:0];
    end

    // Output symbol and disparity registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmds_q <= TOK_CTRL00;
            cnt_q  <= '0;
        end else begin
            assert (cnt_sum == {{2{cnt_sum[DispWidth-1]}}, cnt_sum[DispWidth-1:0]});
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_o = tmds_q;
    assign disp_o = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for the TMDS channel encoder: a driver feeds directed and
// random symbols through a behavioural model into a queue; a monitor pops one
// expectation per clock and compares it with the DUT outputs.
module tb_tmds_channel_encoder;

    localparam bit REG_IN = 1'b0;
    localparam int DW     = 5;
    localparam int LAT    = REG_IN ? 3 : 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [7:0]    data_i = '0;
    logic          de_i = 1'b0;
    logic [1:0]    ctrl_i = 2'b00;
    logic [9:0]    tmds_o;
    logic [DW-1:0] disp_o;

    always #5 clk = ~clk;

    tmds_channel_encoder #(.RegisterInput(REG_IN), .DispWidth(DW)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .data_i (data_i),
        .de_i   (de_i),
        .ctrl_i (ctrl_i),
        .tmds_o (tmds_o),
        .disp_o (disp_o)
    );

    typedef struct {
        logic [9:0] tmds;
        int         disp;
        bit         de;
        logic [7:0] data;
        bit         chk;
        logic [9:0] ctmds;
        int         cdisp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    int   model_cnt = 0;
    int   sym_idx = 0;

    logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // Reference encoder: spec rules evaluated with plain integers
    function automatic logic [8:0] ref_qm(input logic [7:0] d);
        logic [8:0] q;
        int  n;
        bit  xn;
        n  = $countones(d);
        xn = (n > 4) || (n == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Apply one input cycle and enqueue the expected output it will produce
    task automatic drive(input bit rst, input bit de, input logic [1:0] ctrl,
                         input logic [7:0] data, input bit chk,
                         input logic [9:0] ct, input int cd);
        exp_t e;
        logic [8:0] qm;
        int n1, n0;
        rst_i  = rst;
        de_i   = de;
        ctrl_i = ctrl;
        data_i = data;
        e.de = 0; e.data = data; e.chk = chk; e.ctmds = ct; e.cdisp = cd;
        if (rst) begin
            model_cnt = 0;
            exp_q.delete();
            e.tmds = 10'h354; e.disp = 0;
            exp_q.push_back(e);
            e.chk = 0;
            for (int i = 1; i < LAT; i++) exp_q.push_back(e);
        end else begin
            if (!de) begin
                model_cnt = 0;
                e.tmds = tokens[ctrl];
            end else begin
                qm = ref_qm(data);
                n1 = $countones(qm[7:0]);
                n0 = 8 - n1;
                e.de = 1;
                if (model_cnt == 0 || n1 == n0) begin
                    e.tmds = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
                end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
                    e.tmds = {1'b1, qm[8], ~qm[7:0]};
                    model_cnt += (qm[8] ? 2 : 0) + n0 - n1;
                end else begin
                    e.tmds = {1'b0, qm[8], qm[7:0]};
                    model_cnt += n1 - n0 - (qm[8] ? 0 : 2);
                end
            end
            e.disp = model_cnt;
            exp_q.push_back(e);
        end
        started = 1;
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later
    initial begin
        exp_t e;
        int   act_disp;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            sym_idx++;
            act_disp = int'($signed(disp_o));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty sym %0d: no expectation for tmds=%h", sym_idx, tmds_o);
            end else begin
                e = exp_q.pop_front();
                if (tmds_o !== e.tmds) begin
                    errors++;
                    $display("FAIL tmds sym %0d: got %h expected %h", sym_idx, tmds_o, e.tmds);
                end
                checks++;
                if (act_disp != e.disp) begin
                    errors++;
                    $display("FAIL disp sym %0d: got %0d expected %0d", sym_idx, act_disp, e.disp);
                end
                if (e.de) begin
                    checks++;
                    if (tmds_decode(tmds_o) !== e.data) begin
                        errors++;
                        $display("FAIL decode sym %0d: got %h expected %h", sym_idx, tmds_decode(tmds_o), e.data);
                    end
                end
                if (e.chk) begin
                    checks++;
                    if (tmds_o !== e.ctmds || act_disp != e.cdisp) begin
                        errors++;
                        $display("FAIL vector sym %0d: got %h/%0d expected %h/%0d",
                                 sym_idx, tmds_o, act_disp, e.ctmds, e.cdisp);
                    end
                end
                $display("sym %0d tmds=%h disp=%0d exp=%h/%0d", sym_idx, tmds_o, act_disp, e.tmds, e.disp);
            end
        end
    end

    initial begin
        bit de_r;
        // Reset held three cycles while blanking with ctrl 11
        for (int i = 0; i < 3; i++) drive(1, 0, 2'b11, 8'h00, 1, 10'h354, 0);
        drive(0, 0, 2'b11, 8'h00, 1, 10'h2AB, 0);
        // All four control tokens back to back
        drive(0, 0, 2'b00, 8'h00, 1, 10'h354, 0);
        drive(0, 0, 2'b01, 8'h00, 1, 10'h0AB, 0);
        drive(0, 0, 2'b10, 8'h00, 1, 10'h154, 0);
        drive(0, 0, 2'b11, 8'h00, 1, 10'h2AB, 0);
        // Zero pixels from cleared disparity
        drive(0, 1, 2'b00, 8'h00, 1, 10'h100, -8);
        drive(0, 1, 2'b00, 8'h00, 1, 10'h3FF, 2);
        drive(0, 1, 2'b00, 8'h00, 1, 10'h100, -6);
        // Blanking clears disparity, then a full-ones pixel
        drive(0, 0, 2'b00, 8'h00, 1, 10'h354, 0);
        drive(0, 1, 2'b00, 8'hFF, 1, 10'h200, -8);
        drive(0, 0, 2'b01, 8'h00, 1, 10'h0AB, 0);
        // Reset pulse in the middle of an A5 run
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b00, 8'hA5, 0, 10'h000, 0);
        drive(1, 1, 2'b00, 8'hA5, 1, 10'h354, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b00, 8'hA5, 0, 10'h000, 0);
        // Random traffic: long DE runs, occasional blanking and rare resets
        de_r = 1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 15) == 0) de_r = !de_r;
            drive(($urandom_range(0, 499) == 0), de_r, 2'($urandom_range(0, 3)),
                  8'($urandom), 0, 10'h000, 0);
        end
        for (int i = 0; i < LAT; i++) drive(0, 0, 2'b00, 8'h00, 0, 10'h000, 0);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
